// File: rtl/noc_pkg.sv
// -----------------------------------------------------------------------------
// noc_pkg
// Shared NoC constants and types for the leaf uplink path.
//   - flit field positions (destination group / destination leaf)
//   - NUM_NODES, flit typedef, head classification helper
// No ports (package).
// -----------------------------------------------------------------------------
package noc_pkg;

    localparam int unsigned NUM_NODES     = 4;
    localparam int unsigned FLIT_W        = 16;

    localparam int unsigned DEST_GRP_MSB  = 15;
    localparam int unsigned DEST_GRP_LSB  = 12;
    localparam int unsigned DEST_LEAF_MSB = 11;
    localparam int unsigned DEST_LEAF_LSB = 10;

    typedef logic [FLIT_W-1:0] flit_t;

    typedef enum logic {
        CLS_UP    = 1'b0,
        CLS_LOCAL = 1'b1
    } flit_class_e;

    // A flit addressed to our own group and leaf is turned back locally.
    function automatic flit_class_e flit_class(
        input flit_t      f,
        input logic [3:0] grp,
        input logic [1:0] leaf
    );
        if (f[DEST_GRP_MSB:DEST_GRP_LSB] == grp &&
            f[DEST_LEAF_MSB:DEST_LEAF_LSB] == leaf)
            return CLS_LOCAL;
        return CLS_UP;
    endfunction

endpackage

// File: rtl/noc_sync_fifo.sv
// -----------------------------------------------------------------------------
// noc_sync_fifo
// Single-clock FIFO with extra-MSB pointers; full/empty are derived from the
// registered pointers only, so push acceptance never depends on this cycle's pop.
// Ports:
//   clk, reset     clock, asynchronous active-high reset (empties the FIFO)
//   push,push_data write request / data (ignored while full)
//   pop            read request (ignored while empty)
//   full, empty    status
//   head_data      entry at the read pointer (valid when !empty)
// -----------------------------------------------------------------------------
module noc_sync_fifo #(
    parameter int unsigned DWIDTH     = 16,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [DWIDTH-1:0] push_data,
    input  logic              pop,
    output logic              full,
    output logic              empty,
    output logic [DWIDTH-1:0] head_data
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);

    logic [AW:0]       r_wr_ptr;
    logic [AW:0]       r_rd_ptr;
    logic [DWIDTH-1:0] r_mem [FIFO_DEPTH];
    logic              w_do_push;
    logic              w_do_pop;

    assign full      = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign empty     = (r_wr_ptr == r_rd_ptr);
    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;
    assign head_data = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
        end
    end

    // Storage needs no reset: entries are only observed between the pointers.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/leaf_uplink_arbiter.sv
// -----------------------------------------------------------------------------
// leaf_uplink_arbiter
// Leaf-side injection stage: 4 node ingress FIFOs, a round-robin arbiter and
// two registered outputs (spine uplink, local loopback for own-leaf flits).
// Optional build macro: LEAF_UPLINK_STATS_EN adds saturating grant/stall counters.
// Ports:
//   clk, reset                      clock, asynchronous active-high reset
//   node_in_data/valid/ready        4 node ingress streams (node i at [i*DWIDTH +: DWIDTH])
//   link_ready                      uplink backpressure
//   up_out_data/valid               flit toward spine leaf port
//   loop_out_data/valid/ready       locally addressed flits
//   stat_grants, stat_stall         (LEAF_UPLINK_STATS_EN) per-node grants, uplink stall cycles
// -----------------------------------------------------------------------------
module leaf_uplink_arbiter
    import noc_pkg::*;
#(
    parameter logic [3:0]  GROUP_ID   = 4'b0001,
    parameter logic [1:0]  LEAF_ID    = 2'd0,
    parameter int unsigned DWIDTH     = 16,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [4*DWIDTH-1:0]     node_in_data,
    input  logic [3:0]              node_in_valid,
    output logic [3:0]              node_in_ready,
    input  logic                    link_ready,
    output logic [DWIDTH-1:0]       up_out_data,
    output logic                    up_out_valid,
    output logic [DWIDTH-1:0]       loop_out_data,
    output logic                    loop_out_valid,
    input  logic                    loop_out_ready
`ifdef LEAF_UPLINK_STATS_EN
    ,
    output logic [4*16-1:0]         stat_grants,
    output logic [15:0]             stat_stall
`endif
);

    logic [NUM_NODES-1:0] w_full;
    logic [NUM_NODES-1:0] w_empty;
    logic [NUM_NODES-1:0] w_push;
    logic [NUM_NODES-1:0] w_pop;
    logic [NUM_NODES-1:0] w_local;
    logic [NUM_NODES-1:0] w_elig;
    flit_t                w_head [NUM_NODES];

    logic                 w_up_free;
    logic                 w_loop_free;
    logic                 w_gnt_valid;
    logic [1:0]           w_gnt_idx;

    logic [1:0]           r_ptr;
    logic [DWIDTH-1:0]    r_up_data;
    logic                 r_up_valid;
    logic [DWIDTH-1:0]    r_loop_data;
    logic                 r_loop_valid;

    assign node_in_ready = ~w_full;
    assign w_up_free     = !r_up_valid   || link_ready;
    assign w_loop_free   = !r_loop_valid || loop_out_ready;

    for (genvar g = 0; g < NUM_NODES; g++) begin : g_node
        assign w_push[g] = node_in_valid[g] && !w_full[g];
        assign w_pop[g]  = w_gnt_valid && (w_gnt_idx == 2'(g));

        noc_sync_fifo #(
            .DWIDTH     (DWIDTH),
            .FIFO_DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk       (clk),
            .reset     (reset),
            .push      (w_push[g]),
            .push_data (node_in_data[g*DWIDTH +: DWIDTH]),
            .pop       (w_pop[g]),
            .full      (w_full[g]),
            .empty     (w_empty[g]),
            .head_data (w_head[g])
        );

        assign w_local[g] = (flit_class(w_head[g], GROUP_ID, LEAF_ID) == CLS_LOCAL);
        // Eligibility looks only at the output this head needs, so a stuck
        // loopback never blocks other nodes' uplink traffic.
        assign w_elig[g]  = !w_empty[g] && (w_local[g] ? w_loop_free : w_up_free);
    end

    always_comb begin
        logic [1:0] w_idx;
        w_gnt_valid = 1'b0;
        w_gnt_idx   = r_ptr;
        w_idx       = r_ptr;
        for (int unsigned k = 0; k < NUM_NODES; k++) begin
            w_idx = r_ptr + k[1:0];
            if (!w_gnt_valid && w_elig[w_idx]) begin
                w_gnt_valid = 1'b1;
                w_gnt_idx   = w_idx;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ptr        <= '0;
            r_up_data    <= '0;
            r_up_valid   <= 1'b0;
            r_loop_data  <= '0;
            r_loop_valid <= 1'b0;
        end else begin
            if (w_gnt_valid) r_ptr <= w_gnt_idx + 2'd1;

            if (w_gnt_valid && !w_local[w_gnt_idx]) begin
                r_up_data  <= w_head[w_gnt_idx];
                r_up_valid <= 1'b1;
            end else if (link_ready) begin
                r_up_valid <= 1'b0;
            end

            if (w_gnt_valid && w_local[w_gnt_idx]) begin
                r_loop_data  <= w_head[w_gnt_idx];
                r_loop_valid <= 1'b1;
            end else if (loop_out_ready) begin
                r_loop_valid <= 1'b0;
            end
        end
    end

    assign up_out_data    = r_up_data;
    assign up_out_valid   = r_up_valid;
    assign loop_out_data  = r_loop_data;
    assign loop_out_valid = r_loop_valid;

`ifdef LEAF_UPLINK_STATS_EN
    logic [15:0] r_stat_grants [NUM_NODES];
    logic [15:0] r_stat_stall;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUM_NODES; i++) r_stat_grants[i] <= '0;
            r_stat_stall <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_NODES; i++) begin
                if (w_pop[i] && r_stat_grants[i] != '1)
                    r_stat_grants[i] <= r_stat_grants[i] + 16'd1;
            end
            if (r_up_valid && !link_ready && r_stat_stall != '1)
                r_stat_stall <= r_stat_stall + 16'd1;
        end
    end

    for (genvar g = 0; g < NUM_NODES; g++) begin : g_stat
        assign stat_grants[g*16 +: 16] = r_stat_grants[g];
    end
    assign stat_stall = r_stat_stall;
`endif

endmodule

// File: tb/tb_leaf_uplink_arbiter.sv
module tb_leaf_uplink_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] node_in_data;
    logic [3:0]  node_in_valid;
    logic [3:0]  node_in_ready;
    logic        link_ready;
    logic [15:0] up_out_data;
    logic        up_out_valid;
    logic [15:0] loop_out_data;
    logic        loop_out_valid;
    logic        loop_out_ready;
`ifdef LEAF_UPLINK_STATS_EN
    logic [63:0] stat_grants;
    logic [15:0] stat_stall;
`endif

    always #5 clk = ~clk;

    leaf_uplink_arbiter #(
        .GROUP_ID   (4'b0001),
        .LEAF_ID    (2'd0),
        .DWIDTH     (16),
        .FIFO_DEPTH (8)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .node_in_data   (node_in_data),
        .node_in_valid  (node_in_valid),
        .node_in_ready  (node_in_ready),
        .link_ready     (link_ready),
        .up_out_data    (up_out_data),
        .up_out_valid   (up_out_valid),
        .loop_out_data  (loop_out_data),
        .loop_out_valid (loop_out_valid),
        .loop_out_ready (loop_out_ready)
`ifdef LEAF_UPLINK_STATS_EN
        ,
        .stat_grants    (stat_grants),
        .stat_stall     (stat_stall)
`endif
    );

    int          errors = 0;
    int          checks = 0;
    int          pushes [4];
    int          up_fires;
    int          loop_fires;
    logic [7:0]  seq [4];
    logic        lcl [4];
    logic [15:0] q0 [$];
    logic [15:0] q1 [$];
    logic [15:0] q2 [$];
    logic [15:0] q3 [$];
    logic [15:0] ql [$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Flit tag bits [9:8] carry the source node so the model can key its queues.
    function automatic logic [15:0] mkflit(input int n, input logic l, input logic [7:0] s);
        logic [1:0] t;
        t = n[1:0];
        return {(l ? 4'h1 : 4'h2), 2'b00, t, s};
    endfunction

    function automatic int qsize(input logic [1:0] t);
        case (t)
            2'd0:    return q0.size();
            2'd1:    return q1.size();
            2'd2:    return q2.size();
            default: return q3.size();
        endcase
    endfunction

    task automatic qpush(input logic [1:0] t, input logic [15:0] d);
        case (t)
            2'd0:    q0.push_back(d);
            2'd1:    q1.push_back(d);
            2'd2:    q2.push_back(d);
            default: q3.push_back(d);
        endcase
    endtask

    task automatic check_up(input logic [15:0] d);
        logic [15:0] e;
        int          sz;
        sz = qsize(d[9:8]);
        chk("up_expected_pending", 64'(sz != 0), 64'd1);
        if (sz != 0) begin
            case (d[9:8])
                2'd0:    e = q0.pop_front();
                2'd1:    e = q1.pop_front();
                2'd2:    e = q2.pop_front();
                default: e = q3.pop_front();
            endcase
            chk("up_order", 64'(d), 64'(e));
        end
    endtask

    task automatic check_loop(input logic [15:0] d);
        logic [15:0] e;
        chk("loop_expected_pending", 64'(ql.size() != 0), 64'd1);
        if (ql.size() != 0) begin
            e = ql.pop_front();
            chk("loop_order", 64'(d), 64'(e));
        end
    endtask

    task automatic flush_model();
        q0.delete(); q1.delete(); q2.delete(); q3.delete(); ql.delete();
        for (int i = 0; i < 4; i++) begin
            seq[i]    = 8'd0;
            pushes[i] = 0;
        end
    endtask

    // One clock: record transfers that the edge will perform, then advance.
    task automatic tick();
        logic [3:0]  fired;
        logic [15:0] d;
        fired = '0;
        if (!reset) begin
            for (int i = 0; i < 4; i++) begin
                if (node_in_valid[i] && node_in_ready[i]) begin
                    fired[i] = 1'b1;
                    pushes[i]++;
                    d = node_in_data[i*16 +: 16];
                    if (d[15:12] == 4'h1 && d[11:10] == 2'b00) ql.push_back(d);
                    else qpush(d[9:8], d);
                end
            end
            if (up_out_valid && link_ready) begin
                up_fires++;
                check_up(up_out_data);
            end
            if (loop_out_valid && loop_out_ready) begin
                loop_fires++;
                check_loop(loop_out_data);
            end
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            if (fired[i]) begin
                seq[i]++;
                node_in_data[i*16 +: 16] = mkflit(i, lcl[i], seq[i]);
            end
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        flush_model();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        reset          = 1'b1;
        link_ready     = 1'b1;
        loop_out_ready = 1'b1;
        node_in_valid  = 4'hF;
        node_in_data   = 64'h2301_2201_2101_2001;
        up_fires       = 0;
        loop_fires     = 0;
        for (int i = 0; i < 4; i++) lcl[i] = 1'b0;
        flush_model();

        // 1: reset with valids high, then first-flit latency
        repeat (3) tick();
        chk("rst_up_valid",   64'(up_out_valid),   64'd0);
        chk("rst_loop_valid", 64'(loop_out_valid), 64'd0);
        chk("rst_ready",      64'(node_in_ready),  64'hF);
        chk("rst_up_data",    64'(up_out_data),    64'd0);
        chk("rst_loop_data",  64'(loop_out_data),  64'd0);
`ifdef LEAF_UPLINK_STATS_EN
        chk("rst_stat_grants", stat_grants, 64'd0);
        chk("rst_stat_stall",  64'(stat_stall), 64'd0);
`endif
        node_in_valid       = 4'b0001;
        node_in_data[15:0]  = 16'h2ABC;
        reset               = 1'b0;
        tick();
        node_in_valid = 4'b0000;
        chk("t1_valid_after_push", 64'(up_out_valid), 64'd0);
        tick();
        chk("t1_valid_after_grant", 64'(up_out_valid), 64'd1);
        chk("t1_data", 64'(up_out_data), 64'h2ABC);
        tick();
        chk("t1_valid_after_take", 64'(up_out_valid), 64'd0);

        // 2: all four nodes stream uplink flits
        do_reset();
        for (int i = 0; i < 4; i++) node_in_data[i*16 +: 16] = mkflit(i, 1'b0, 8'd0);
        node_in_valid = 4'hF;
        for (int k = 0; k <= 100; k++) begin
            tick();
            if (k >= 1 && k <= 16) begin
                chk("t2_one_per_cycle", 64'(up_out_valid), 64'd1);
                chk("t2_rr_node", 64'(up_out_data[9:8]), 64'((k - 1) % 4));
            end
        end
`ifdef LEAF_UPLINK_STATS_EN
        for (int i = 0; i < 4; i++) chk("t2_stat_grants", 64'(stat_grants[i*16 +: 16]), 64'd25);
`endif
        node_in_valid = 4'h0;
        repeat (40) tick();
        chk("t2_drained", 64'(q0.size() + q1.size() + q2.size() + q3.size()), 64'd0);

        // 3: blocked loopback on node 1 does not stall node 2 uplink traffic
        seq[1] = 8'd0;
        lcl[1] = 1'b1;
        node_in_data[31:16] = mkflit(1, 1'b1, seq[1]);
        node_in_data[47:32] = mkflit(2, 1'b0, seq[2]);
        loop_out_ready = 1'b0;
        loop_fires     = 0;
        pushes[1]      = 0;
        node_in_valid  = 4'b0110;
        repeat (12) tick();
        chk("t3_loop_valid", 64'(loop_out_valid), 64'd1);
        chk("t3_loop_data",  64'(loop_out_data),  64'h1100);
        chk("t3_up_flows",   64'(up_out_valid),   64'd1);
        chk("t3_up_node2",   64'(up_out_data[9:8]), 64'd2);
        repeat (6) tick();
        chk("t3_loop_held",  64'(loop_out_data),  64'h1100);
        chk("t3_up_flows2",  64'(up_out_valid),   64'd1);
        chk("t3_node1_full", 64'(node_in_ready[1]), 64'd0);
        chk("t3_node1_push", 64'(pushes[1]), 64'd9);
        node_in_valid  = 4'b0000;
        loop_out_ready = 1'b1;
        repeat (20) tick();
        chk("t3_loop_count", 64'(loop_fires), 64'd9);
        chk("t3_drained", 64'(ql.size() + q2.size()), 64'd0);
        lcl[1] = 1'b0;

        // 4: uplink stall, node 0 fills its FIFO
        link_ready = 1'b0;
        pushes[0]  = 0;
        up_fires   = 0;
        node_in_data[15:0] = mkflit(0, 1'b0, seq[0]);
        node_in_valid = 4'b0001;
        repeat (22) tick();
        chk("t4_pushes", 64'(pushes[0]), 64'd9);
        chk("t4_ready0", 64'(node_in_ready), 64'hE);
        chk("t4_up_held", 64'(up_out_valid), 64'd1);
`ifdef LEAF_UPLINK_STATS_EN
        chk("t4_stat_stall", 64'(stat_stall), 64'd20);
`endif

        // 5: full FIFO pops while a push is offered: refused now, taken next
        link_ready = 1'b1;
        tick();
        chk("t5_refused", 64'(pushes[0]), 64'd9);
        chk("t5_ready_back", 64'(node_in_ready[0]), 64'd1);
        tick();
        chk("t5_accepted", 64'(pushes[0]), 64'd10);
        node_in_valid = 4'b0000;
        repeat (15) tick();
        chk("t5_all_out", 64'(up_fires), 64'd10);
        chk("t5_drained", 64'(q0.size()), 64'd0);

        // 6: reset mid-stream discards everything
        for (int i = 0; i < 4; i++) node_in_data[i*16 +: 16] = mkflit(i, 1'b0, seq[i]);
        node_in_valid = 4'hF;
        repeat (5) tick();
        reset = 1'b1;
        #1;
        chk("t6_rst_up", 64'(up_out_valid), 64'd0);
        chk("t6_rst_ready", 64'(node_in_ready), 64'hF);
        flush_model();
        tick();
        reset = 1'b0;
        node_in_valid = 4'h0;
        repeat (5) tick();
        chk("t6_no_survivor_up", 64'(up_out_valid), 64'd0);
        chk("t6_no_survivor_loop", 64'(loop_out_valid), 64'd0);
`ifdef LEAF_UPLINK_STATS_EN
        chk("t6_stat_clear", 64'(stat_stall), 64'd0);
`endif
        chk("final_queues_empty",
            64'(q0.size() + q1.size() + q2.size() + q3.size() + ql.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
